// File: rtl/waveform_lut_loader.sv
// Writer side of the waveform LUT RAM: takes packed bytes over valid/ready and writes each one
// as four 2-bit entries (LSB pair first) to sequential LUT addresses.
module waveform_lut_loader #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned LEN_W  = 13
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  byte_len,
   input  logic              abort,
   input  logic [7:0]        s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              lut_we,
   output logic [ADDR_W-1:0] lut_addr,
   output logic [1:0]        lut_din
);

   localparam int unsigned EndW = ADDR_W + LEN_W + 2;

   typedef enum logic [1:0] {StIdle, StRecv, StUnpack, StDone} state_e;

   state_e            state_q, state_d;
   logic [1:0]        phase_q, phase_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        byte_q, byte_d;
   logic              s_ready_q, s_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic              lut_we_q, lut_we_d;
   logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
   logic [1:0]        lut_din_q, lut_din_d;

   logic [EndW-1:0]   end_addr;
   logic [EndW-1:0]   lut_size;
   logic [1:0]        phase_nxt;

   // Wide enough that start_addr + 4*byte_len can never overflow.
   assign end_addr  = EndW'(start_addr) + (EndW'(byte_len) << 2);
   assign lut_size  = EndW'(1) << ADDR_W;
   assign phase_nxt = phase_q + 2'd1;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      remain_d   = remain_q;
      addr_d     = addr_q;
      byte_d     = byte_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      lut_we_d   = 1'b0;
      lut_addr_d = lut_addr_q;
      lut_din_d  = lut_din_q;

      if (abort) begin
         state_d = StIdle;
         phase_d = 2'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (end_addr > lut_size) begin
                     error_d = 1'b1;
                  end else if (byte_len == '0) begin
                     state_d = StDone;
                  end else begin
                     addr_d   = start_addr;
                     remain_d = byte_len;
                     state_d  = StRecv;
                  end
               end
            end
            StRecv: begin
               // Phase 0 is issued straight from the accepted byte so writes begin next cycle.
               if (s_valid && s_ready_q) begin
                  byte_d     = s_data;
                  remain_d   = remain_q - 1'b1;
                  lut_we_d   = 1'b1;
                  lut_addr_d = addr_q;
                  lut_din_d  = s_data[1:0];
                  addr_d     = addr_q + 1'b1;
                  phase_d    = 2'd0;
                  state_d    = StUnpack;
               end
            end
            StUnpack: begin
               if (phase_q == 2'd3) begin
                  if (remain_q == '0) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StRecv;
                  end
               end else begin
                  lut_we_d   = 1'b1;
                  lut_addr_d = addr_q;
                  lut_din_d  = byte_q[{phase_nxt, 1'b0} +: 2];
                  addr_d     = addr_q + 1'b1;
                  phase_d    = phase_nxt;
               end
            end
            StDone: begin
               // Arriving with done already raised ends the load; a zero-length load raises it here.
               if (done_q) begin
                  state_d = StIdle;
               end else begin
                  done_d = 1'b1;
               end
            end
         endcase
      end

      s_ready_d = (state_d == StRecv);
      busy_d    = (state_d == StRecv) || (state_d == StUnpack);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         phase_q    <= 2'd0;
         remain_q   <= '0;
         addr_q     <= '0;
         byte_q     <= 8'd0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         lut_we_q   <= 1'b0;
         lut_addr_q <= '0;
         lut_din_q  <= 2'd0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         remain_q   <= remain_d;
         addr_q     <= addr_d;
         byte_q     <= byte_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         lut_we_q   <= lut_we_d;
         lut_addr_q <= lut_addr_d;
         lut_din_q  <= lut_din_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   assign lut_we   = lut_we_q;
   assign lut_addr = lut_addr_q;
   assign lut_din  = lut_din_q;

endmodule

// File: doc/waveform_lut_loader.md
Name: waveform_lut_loader

Overview:
- Writer side of the waveform LUT dual-port RAM (16384 x 2-bit entries).
- Takes a byte stream from the host link, for example the SPI/USB register bridge, over a valid/ready handshake.
- Unpacks each byte into four 2-bit LUT entries and writes them to sequential LUT addresses through the RAM's second port.
- Lets firmware replace the power-on default waveform at runtime without touching the EPD timing side of the RAM.

Parameters:
- ADDR_W, 14, LUT address width; the LUT depth is 2^ADDR_W entries.
- LEN_W, 13, width of the byte-count input; it must hold 2^(ADDR_W-2) bytes.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- start_addr  input  ADDR_W  first LUT entry address; sampled with start.
- byte_len  input  LEN_W  number of bytes to load; sampled with start.
- abort  input  1  cancels any load in progress.
- s_data  input  8  packed waveform byte.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts s_data this cycle.
- busy  output  1  a load is active (RECV or UNPACK).
- done  output  1  one-cycle pulse when a load completes.
- error  output  1  one-cycle pulse when start is rejected.
- lut_we  output  1  LUT write enable.
- lut_addr  output  ADDR_W  LUT write address.
- lut_din  output  2  LUT write data.

Behaviour:
- All outputs are registered.
- Reset values: s_ready 0, busy 0, done 0, error 0, lut_we 0, lut_addr 0, lut_din 0.
- Internal state after reset: IDLE, phase 0, remaining count 0.
- Asserting rstn low mid-load clears everything asynchronously. No partial write occurs after reset asserts.
- States: IDLE, RECV, UNPACK, DONE.
- IDLE, start=1:
  - Compute end = start_addr + 4*byte_len at ADDR_W+LEN_W+2 bits, with no truncation.
  - If end > 2^ADDR_W: pulse error the next cycle, stay in IDLE, perform no writes.
  - Else if byte_len == 0: go to DONE, which pulses done the next cycle with no writes.
  - Else: latch the address and count, then go to RECV.
- start outside IDLE is ignored.
- RECV:
  - s_ready=1 and busy=1.
  - On s_valid & s_ready, latch s_data, decrement the remaining count and go to UNPACK, phase 0.
  - If s_valid is low, wait indefinitely.
- UNPACK:
  - s_ready=0, busy=1.
  - Four consecutive cycles, phases 0..3.
  - In each phase, the registered outputs present lut_we=1, lut_addr=current address and lut_din=byte[2p+1:2p] (LSB pair first). The current address then increments by 1.
  - Timing: the byte handshake at edge E0 gives write cycles starting at E0+1 for four cycles.
  - After phase 3: if the remaining count is 0, go to DONE; otherwise go to RECV. s_ready is high in the cycle after the last write.
  - Throughput is 1 byte per 5 cycles at best.
- DONE:
  - done=1 for exactly one cycle, busy=0, lut_we=0, then IDLE.
  - done is never asserted in the same cycle as lut_we.
- Address never wraps: the bound check at start guarantees the final write address is at most 2^ADDR_W-1.
  - The exact fit start_addr + 4*byte_len == 2^ADDR_W is legal.
- abort:
  - Highest priority below reset, honoured in any state.
  - Next cycle: IDLE, lut_we=0, s_ready=0, busy=0, no done pulse.
  - Writes already issued stay in the LUT.
  - abort and start in the same cycle: abort wins and start is ignored.
- s_data is ignored whenever s_ready=0, and the handshake requires no protocol from the host beyond valid/ready.
- lut_addr and lut_din hold their last values when lut_we=0.

Test Plan:
- Single byte at address 0:
  - Stimulus: start_addr=0, byte_len=1, s_data=0xE4.
  - Response: writes (0,00),(1,01),(2,10),(3,11) on four consecutive cycles starting 1 cycle after the handshake, then done 1 cycle after the last write, then busy=0.
- Bounds at the top of the LUT:
  - start_addr=0x3FFC, byte_len=1: writes 0x3FFC..0x3FFF, then done.
  - start_addr=0x3FFC, byte_len=2: error pulse, zero lut_we cycles, s_ready stays 0.
- Zero length:
  - start with byte_len=0: done pulses 2 cycles after start, lut_we never asserted.
- Backpressure and multi-byte data:
  - Stimulus: start_addr=0x100, byte_len=3, bytes 0x00, 0xFF, 0x1B, with s_valid gapped by 0-7 random idle cycles.
  - Response: exactly 12 writes to 0x100..0x10B with data 0,0,0,0,3,3,3,3,3,2,1,0; s_ready=0 during every UNPACK cycle.
- Abort mid-load:
  - Stimulus: byte_len=4; assert abort during UNPACK phase 2 of byte 2.
  - Response: lut_we low from the next cycle, no done pulse; a following start with byte_len=1 completes normally.
- Reset mid-load:
  - Stimulus: pull rstn low asynchronously mid-UNPACK.
  - Response: all outputs 0 immediately, before the next clock edge. After release the block is in IDLE and accepts a new start.
